// File: rtl/block_nest_checker.sv
// Streaming begin/end (and optionally case/endcase) nesting checker over an ASCII byte stream.
// Optional macro BLOCK_NEST_CASE_PAIR_EN enables case/endcase recognition as a second block type.
module block_nest_checker #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEPTH_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned TOK_MAX = 7;
  localparam int unsigned LEN_W   = 4;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDER    = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_OVER     = 2'b11;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_OPEN_B,
    CLS_OPEN_C,
    CLS_CLOSE_B,
    CLS_CLOSE_C
  } tok_cls_e;

  logic [TOK_MAX-1:0][7:0] tok_q, tok_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [STACK_DEPTH-1:0]  stack_q, stack_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;

  tok_cls_e   cls;
  logic       is_open, is_close, cls_type;
  logic       is_delim, under, mismatch, over;
  logic [7:0] ch_fold;

  // Classify the pending token; a saturated length (8) never matches any keyword.
  always_comb begin
    cls = CLS_NONE;
    if (len_q == LEN_W'(5) && {tok_q[0], tok_q[1], tok_q[2], tok_q[3], tok_q[4]} == "begin")
      cls = CLS_OPEN_B;
    if (len_q == LEN_W'(3) && {tok_q[0], tok_q[1], tok_q[2]} == "end")
      cls = CLS_CLOSE_B;
`ifdef BLOCK_NEST_CASE_PAIR_EN
    if (len_q == LEN_W'(4) && {tok_q[0], tok_q[1], tok_q[2], tok_q[3]} == "case")
      cls = CLS_OPEN_C;
    if (len_q == LEN_W'(7) &&
        {tok_q[0], tok_q[1], tok_q[2], tok_q[3], tok_q[4], tok_q[5], tok_q[6]} == "endcase")
      cls = CLS_CLOSE_C;
`endif
  end

  // Commit checks shared by the real commit and the virtual commit behind result.
  always_comb begin
    is_open  = (cls == CLS_OPEN_B)  || (cls == CLS_OPEN_C);
    is_close = (cls == CLS_CLOSE_B) || (cls == CLS_CLOSE_C);
    cls_type = (cls == CLS_OPEN_C)  || (cls == CLS_CLOSE_C);
    under    = is_close && (depth_q == '0);
    mismatch = is_close && (depth_q != '0) && (stack_q[0] != cls_type);
    over     = is_open && (depth_q == DEPTH_W'(STACK_DEPTH));
    is_delim = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A);
    ch_fold  = ((in >= 8'h41) && (in <= 8'h5A)) ? (in | 8'h20) : in;
    result   = !error_q &&
               (((cls == CLS_NONE) && (depth_q == '0)) ||
                (is_close && (depth_q == DEPTH_W'(1)) && (stack_q[0] == cls_type)));
  end

  // Stack is a shift register with the top of stack at bit 0.
  always_comb begin
    tok_d      = tok_q;
    len_d      = len_q;
    stack_d    = stack_q;
    depth_d    = depth_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    if (in_valid) begin
      if (is_delim) begin
        len_d = '0;
        if (!error_q) begin
          if (under) begin
            error_d    = 1'b1;
            err_code_d = ERR_UNDER;
          end else if (mismatch) begin
            error_d    = 1'b1;
            err_code_d = ERR_MISMATCH;
          end else if (over) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVER;
          end else if (is_open) begin
            stack_d = {stack_q[STACK_DEPTH-2:0], cls_type};
            depth_d = depth_q + DEPTH_W'(1);
          end else if (is_close) begin
            stack_d = {1'b0, stack_q[STACK_DEPTH-1:1]};
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
      end else begin
        for (int i = 0; i < TOK_MAX; i++) begin
          if (len_q == LEN_W'(i)) tok_d[i] = ch_fold;
        end
        if (len_q != LEN_W'(TOK_MAX + 1)) len_d = len_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_q      <= '0;
      len_q      <= '0;
      stack_q    <= '0;
      depth_q    <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      tok_q      <= tok_d;
      len_q      <= len_d;
      stack_q    <= stack_d;
      depth_q    <= depth_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign depth    = depth_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: two instances (default and 2-deep stack) against a string/array model.
module tb_block_nest_checker;

  localparam int unsigned SD_B = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_ch;
  logic       in_valid;
  logic       result_a, error_a, result_b, error_b;
  logic [4:0] depth_a;
  logic [1:0] depth_b;
  logic [1:0] code_a, code_b;

  block_nest_checker dut_a (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .result(result_a), .depth(depth_a), .error(error_a), .err_code(code_a)
  );

  block_nest_checker #(.STACK_DEPTH(SD_B), .DEPTH_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .result(result_b), .depth(depth_b), .error(error_b), .err_code(code_b)
  );

  always #5 clk = ~clk;

  // Model state: pending token as a lowercase string, per-instance stack as an array.
  string tok;
  int    lim [2];
  int    m_dep [2];
  bit    m_err [2];
  int    m_code [2];
  bit    m_stk [2][256];
  bit    case_en;
  int    n_checks;
  int    n_fail;

  // 0 none, 1 open begin, 2 open case, 3 close end, 4 close endcase
  function automatic int cls_of(string t);
    if (t == "begin") return 1;
    if (t == "end") return 3;
    if (case_en && t == "case") return 2;
    if (case_en && t == "endcase") return 4;
    return 0;
  endfunction

  function automatic void commit(int k, int c);
    bit t;
    t = (c == 2 || c == 4);
    if (m_err[k] || c == 0) return;
    if (c <= 2) begin
      if (m_dep[k] == lim[k]) begin
        m_err[k] = 1'b1; m_code[k] = 3;
      end else begin
        m_stk[k][m_dep[k]] = t; m_dep[k]++;
      end
    end else begin
      if (m_dep[k] == 0) begin
        m_err[k] = 1'b1; m_code[k] = 1;
      end else if (m_stk[k][m_dep[k]-1] != t) begin
        m_err[k] = 1'b1; m_code[k] = 2;
      end else begin
        m_dep[k]--;
      end
    end
  endfunction

  function automatic int model_result(int k);
    int c;
    bit t;
    c = cls_of(tok);
    t = (c == 2 || c == 4);
    if (m_err[k]) return 0;
    if (c == 0) return (m_dep[k] == 0) ? 1 : 0;
    if (c <= 2) return 0;
    if (m_dep[k] == 0) return 0;
    if (m_stk[k][m_dep[k]-1] != t) return 0;
    return (m_dep[k] == 1) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    tok = "";
    for (int k = 0; k < 2; k++) begin
      m_dep[k] = 0; m_err[k] = 1'b0; m_code[k] = 0;
    end
  endfunction

  function automatic void model_consume(logic [7:0] ch);
    logic [7:0] lc;
    if (ch == 8'h20 || ch == 8'h09 || ch == 8'h0A) begin
      for (int k = 0; k < 2; k++) commit(k, cls_of(tok));
      tok = "";
    end else begin
      lc = (ch >= 8'h41 && ch <= 8'h5A) ? ch + 8'd32 : ch;
      tok = $sformatf("%s%c", tok, lc);
    end
  endfunction

  task automatic cmp_one(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Outputs depend only on registered state, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    cmp_one("a.result", int'(result_a), model_result(0));
    cmp_one("a.depth", int'(depth_a), m_dep[0]);
    cmp_one("a.error", int'(error_a), int'(m_err[0]));
    cmp_one("a.err_code", int'(code_a), m_code[0]);
    cmp_one("b.result", int'(result_b), model_result(1));
    cmp_one("b.depth", int'(depth_b), m_dep[1]);
    cmp_one("b.error", int'(error_b), int'(m_err[1]));
    cmp_one("b.err_code", int'(code_b), m_code[1]);
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(logic [7:0] ch, bit v);
    in_ch = ch;
    in_valid = v;
    @(posedge clk);
    if (v && !reset) model_consume(ch);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
  endtask

  function automatic string pick_word();
    int    r;
    int    n;
    string s;
    r = $urandom_range(0, 19);
    s = "";
    if (r <= 5) s = "begin";
    else if (r <= 11) s = "end";
    else if (r <= 13) s = "case";
    else if (r <= 15) s = "endcase";
    else if (r == 16) s = "beginx";
    else if (r == 17) s = "endcasex";
    else if (r == 18) s = "begi";
    else begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, $urandom_range(97, 122));
    end
    return s;
  endfunction

  task automatic send_word(string w);
    logic [7:0] ch;
    for (int i = 0; i < w.len(); i++) begin
      ch = w[i];
      if (ch >= 8'h61 && ch <= 8'h7A && $urandom_range(0, 1) == 1) ch = ch - 8'd32;
      if ($urandom_range(0, 7) == 0) step(8'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 150) == 0) pulse_reset();
      step(ch, 1'b1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dl [3];
    int nd;
    dl[0] = 8'h20; dl[1] = 8'h09; dl[2] = 8'h0A;
`ifdef BLOCK_NEST_CASE_PAIR_EN
    case_en = 1'b1;
`else
    case_en = 1'b0;
`endif
    lim[0] = 16; lim[1] = SD_B;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; in_ch = 8'h00; in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cmp_one("lit.rst.result", int'(result_a), 1);
    cmp_one("lit.rst.depth", int'(depth_a), 0);
    cmp_one("lit.rst.err_code", int'(code_a), 0);

    send_str("begin");
    cmp_one("lit.begin_n.result", int'(result_a), 0);
    step(8'h20, 1'b1);
    cmp_one("lit.begin_sp.depth", int'(depth_a), 1);
    send_str("end");
    cmp_one("lit.end_d.result", int'(result_a), 1);
    step(8'h20, 1'b1);
    cmp_one("lit.end_sp.depth", int'(depth_a), 0);
    cmp_one("lit.end_sp.error", int'(error_a), 0);

    pulse_reset();
    send_str("END");
    cmp_one("lit.END_D.result", int'(result_a), 0);
    step(8'h20, 1'b1);
    cmp_one("lit.under.error", int'(error_a), 1);
    cmp_one("lit.under.err_code", int'(code_a), 1);
    send_str("begin end ");
    cmp_one("lit.sticky.depth", int'(depth_a), 0);
    cmp_one("lit.sticky.err_code", int'(code_a), 1);
    cmp_one("lit.sticky.result", int'(result_a), 0);

    pulse_reset();
    send_str("case end ");
    cmp_one("lit.case_end.err_code", int'(code_a), case_en ? 2 : 1);
    cmp_one("lit.case_end.depth", int'(depth_a), case_en ? 1 : 0);

    pulse_reset();
    send_str("begin begin begin ");
    cmp_one("lit.ovf.b_depth", int'(depth_b), 2);
    cmp_one("lit.ovf.b_err_code", int'(code_b), 3);
    cmp_one("lit.ovf.b_result", int'(result_b), 0);
    cmp_one("lit.ovf.a_depth", int'(depth_a), 3);
    cmp_one("lit.ovf.a_error", int'(error_a), 0);

    pulse_reset();
    send_str("begin");
    cmp_one("lit.beginx_n.result", int'(result_a), 0);
    step("x", 1'b1);
    cmp_one("lit.beginx_x.result", int'(result_a), 1);
    send_str(" end ");
    cmp_one("lit.beginx_end.err_code", int'(code_a), 1);

    pulse_reset();
    send_str("endcasex ");
    cmp_one("lit.sat.error", int'(error_a), 0);
    cmp_one("lit.sat.result", int'(result_a), 1);
    send_str("ENDCASE");
    cmp_one("lit.endcase_pend.result", int'(result_a), case_en ? 0 : 1);
    step("X", 1'b1);
    cmp_one("lit.endcasex_pend.result", int'(result_a), 1);
    step(8'h0A, 1'b1);

    pulse_reset();
    send_str("beg");
    pulse_reset();
    step("Q", 1'b0);
    send_str("in");
    step("e", 1'b0);
    step(8'h09, 1'b1);
    cmp_one("lit.mid_rst.error", int'(error_a), 0);
    cmp_one("lit.mid_rst.depth", int'(depth_a), 0);
    send_str("end ");
    cmp_one("lit.mid_rst_end.err_code", int'(code_a), 1);

    for (int w = 0; w < 1500; w++) begin
      if ($urandom_range(0, 40) == 0) pulse_reset();
      send_word(pick_word());
      nd = $urandom_range(1, 2);
      for (int d = 0; d < nd; d++) step(dl[$urandom_range(0, 2)], 1'b1);
    end
    step(8'h20, 1'b0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
